// File: rtl/countdown_mmss.sv
// rtl/countdown_mmss.sv - BCD mm:ss countdown timer with done pulse and alarm
// Optional feature macro: COUNTDOWN_BLINK_EN (alarm toggles on each ena tick while in ALARM)
module countdown_mmss #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       load,
  input  logic [3:0] set_so,
  input  logic [2:0] set_st,
  input  logic [3:0] set_mo,
  input  logic [2:0] set_mt,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  output logic [3:0] so,
  output logic [2:0] st,
  output logic [3:0] mo,
  output logic [2:0] mt,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0);

  state_t          state_q, state_d;
  logic [3:0]      so_d, mo_d, ld_so, ld_mo, dec_so, dec_mo;
  logic [2:0]      st_d, mt_d, ld_st, ld_mt, dec_st, dec_mt;
  logic            running_d, done_d, alarm_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic            cnt_zero, dec_zero, start_go;

  // Load values clamp into legal BCD ranges: ones to 9, tens to 5
  always_comb begin
    ld_so = (set_so > 4'd9) ? 4'd9 : set_so;
    ld_mo = (set_mo > 4'd9) ? 4'd9 : set_mo;
    ld_st = (set_st > 3'd5) ? 3'd5 : set_st;
    ld_mt = (set_mt > 3'd5) ? 3'd5 : set_mt;
  end

  // One-second decrement with borrow rippling seconds-ones up to minutes-tens
  always_comb begin
    dec_so = so;
    dec_st = st;
    dec_mo = mo;
    dec_mt = mt;
    if (so != 4'd0) begin
      dec_so = so - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (st != 3'd0) begin
        dec_st = st - 3'd1;
      end else begin
        dec_st = 3'd5;
        if (mo != 4'd0) begin
          dec_mo = mo - 4'd1;
        end else begin
          dec_mo = 4'd9;
          if (mt != 3'd0) dec_mt = mt - 3'd1;
        end
      end
    end
    cnt_zero = (so == 4'd0) && (st == 3'd0) && (mo == 4'd0) && (mt == 3'd0);
    dec_zero = (dec_so == 4'd0) && (dec_st == 3'd0) && (dec_mo == 4'd0) && (dec_mt == 3'd0);
    start_go = start && !stop;
  end

  // Next state, next count and next flag values; load takes priority over start
  always_comb begin
    state_d = state_q;
    so_d    = so;
    st_d    = st;
    mo_d    = mo;
    mt_d    = mt;
    done_d  = 1'b0;
    alarm_d = alarm;
    acnt_d  = acnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          {mt_d, mo_d, st_d, so_d} = {ld_mt, ld_mo, ld_st, ld_so};
        end else if (start_go && !cnt_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (ena) begin
          {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
          if (dec_zero) begin
            state_d = ALARM;
            done_d  = 1'b1;
            alarm_d = 1'b1;
            acnt_d  = '0;
          end
        end
      end
      PAUSE: begin
        if (load) begin
          {mt_d, mo_d, st_d, so_d} = {ld_mt, ld_mo, ld_st, ld_so};
          state_d = IDLE;
        end else if (start_go) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (load || ack) begin
          if (load) {mt_d, mo_d, st_d, so_d} = {ld_mt, ld_mo, ld_st, ld_so};
          state_d = IDLE;
          alarm_d = 1'b0;
        end else if (ena) begin
          if ((ALARM_TICKS > 0) && (acnt_q == ALARM_LAST)) begin
            state_d = IDLE;
            alarm_d = 1'b0;
          end else begin
            if (ALARM_TICKS > 0) acnt_d = acnt_q + AW'(1);
`ifdef COUNTDOWN_BLINK_EN
            alarm_d = !alarm;
`else
            alarm_d = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        alarm_d = 1'b0;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State, count and flag registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      so      <= 4'd0;
      st      <= 3'd0;
      mo      <= 4'd0;
      mt      <= 3'd0;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      so      <= so_d;
      st      <= st_d;
      mo      <= mo_d;
      mt      <= mt_d;
      running <= running_d;
      done    <= done_d;
      alarm   <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

endmodule

// File: tb/tb_countdown_mmss.sv
// tb/tb_countdown_mmss.sv - scoreboard bench for countdown_mmss (ALARM_TICKS=3 and 0 side by side)
module tb_countdown_mmss;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic       clk = 1'b0, res = 1'b0, ena = 1'b0, load = 1'b0;
  logic       start = 1'b0, stop = 1'b0, ack = 1'b0;
  logic [3:0] set_so = 4'd0, set_mo = 4'd0;
  logic [2:0] set_st = 3'd0, set_mt = 3'd0;

  logic [3:0] so_a, mo_a, so_b, mo_b;
  logic [2:0] st_a, mt_a, st_b, mt_b;
  logic       running_a, done_a, alarm_a, running_b, done_b, alarm_b;

  countdown_mmss #(.ALARM_TICKS(3)) dut_a (
    .clk(clk), .res(res), .ena(ena), .load(load),
    .set_so(set_so), .set_st(set_st), .set_mo(set_mo), .set_mt(set_mt),
    .start(start), .stop(stop), .ack(ack),
    .so(so_a), .st(st_a), .mo(mo_a), .mt(mt_a),
    .running(running_a), .done(done_a), .alarm(alarm_a)
  );

  countdown_mmss #(.ALARM_TICKS(0)) dut_b (
    .clk(clk), .res(res), .ena(ena), .load(load),
    .set_so(set_so), .set_st(set_st), .set_mo(set_mo), .set_mt(set_mt),
    .start(start), .stop(stop), .ack(ack),
    .so(so_b), .st(st_b), .mo(mo_b), .mt(mt_b),
    .running(running_b), .done(done_b), .alarm(alarm_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] ea;
    logic [16:0] eb;
  } item_t;

  item_t sb[$];
  item_t mon_it;
  int    checks = 0;
  int    failures = 0;
  logic [16:0] ga, gb;

  // Expected snapshot {mt,mo,st,so,running,done,alarm}; minutes/seconds given in decimal
  task automatic push_exp(input string nm, input int m, input int s, input bit r, input bit d,
                          input bit aa, input bit ab);
    item_t it;
    logic [16:0] base;
    base = {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), r, d, 1'b0};
    it.name = nm;
    it.ea = base | {16'd0, aa};
    it.eb = base | {16'd0, ab};
    sb.push_back(it);
  endtask

  // Monitor: compares one queued expectation per falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        mon_it = sb.pop_front();
        ga = {mt_a, mo_a, st_a, so_a, running_a, done_a, alarm_a};
        gb = {mt_b, mo_b, st_b, so_b, running_b, done_b, alarm_b};
        checks++;
        if (ga !== mon_it.ea) begin
          failures++;
          $display("FAIL %s dut_a got=%h exp=%h", mon_it.name, ga, mon_it.ea);
        end
        checks++;
        if (gb !== mon_it.eb) begin
          failures++;
          $display("FAIL %s dut_b got=%h exp=%h", mon_it.name, gb, mon_it.eb);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; ena = 1'b0;
  endtask

  task automatic do_load(input int t_mt, input int t_mo, input int t_st, input int t_so);
    set_mt = 3'(t_mt); set_mo = 4'(t_mo); set_st = 3'(t_st); set_so = 4'(t_so);
    load = 1'b1;
    cyc();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      ena = 1'b1;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b0;
    cyc(); cyc();
    push_exp("reset", 0, 0, 0, 0, 0, 0);
    #2 res = 1'b1;

    // 01:00 counts down to 00:00 over 60 ticks
    do_load(0, 1, 0, 0);   push_exp("load_0100", 1, 0, 0, 0, 0, 0);
    start = 1'b1; cyc();   push_exp("start_run", 1, 0, 1, 0, 0, 0);
    tick(1);               push_exp("tick1", 0, 59, 1, 0, 0, 0);
    tick(58);              push_exp("tick59", 0, 1, 1, 0, 0, 0);
    tick(1);               push_exp("tick60", 0, 0, 0, 1, 1, 1);
    cyc();                 push_exp("done_fall", 0, 0, 0, 0, 1, 1);
    tick(1);               push_exp("al_t1", 0, 0, 0, 0, !BL, !BL);
    tick(1);               push_exp("al_t2", 0, 0, 0, 0, 1, 1);
    tick(1);               push_exp("al_t3", 0, 0, 0, 0, 0, !BL);
    tick(16);
    tick(1);               push_exp("al_t20", 0, 0, 0, 0, 0, 1);
    ack = 1'b1; cyc();     push_exp("ack", 0, 0, 0, 0, 0, 0);

    // Borrow across all digits, then pause and reload from PAUSE
    do_load(1, 0, 0, 0);   push_exp("load_1000", 10, 0, 0, 0, 0, 0);
    start = 1'b1; cyc();   push_exp("start_1000", 10, 0, 1, 0, 0, 0);
    tick(1);               push_exp("borrow", 9, 59, 1, 0, 0, 0);
    stop = 1'b1; cyc();    push_exp("stop", 9, 59, 0, 0, 0, 0);
    do_load(0, 0, 0, 5);   push_exp("load_pause", 0, 5, 0, 0, 0, 0);

    // Pause/resume with coincident ticks
    start = 1'b1; ena = 1'b1; cyc(); push_exp("start_tick", 0, 5, 1, 0, 0, 0);
    tick(1);               push_exp("p_t1", 0, 4, 1, 0, 0, 0);
    tick(1);               push_exp("p_t2", 0, 3, 1, 0, 0, 0);
    stop = 1'b1; ena = 1'b1; cyc(); push_exp("stop_tick", 0, 3, 0, 0, 0, 0);
    tick(3);               push_exp("paused", 0, 3, 0, 0, 0, 0);
    start = 1'b1; stop = 1'b1; cyc(); push_exp("stop_wins", 0, 3, 0, 0, 0, 0);
    start = 1'b1; cyc();   push_exp("resume", 0, 3, 1, 0, 0, 0);
    do_load(0, 7, 4, 5);   push_exp("load_run", 0, 3, 1, 0, 0, 0);
    tick(2);               push_exp("p_t4", 0, 1, 1, 0, 0, 0);
    tick(1);               push_exp("p_end", 0, 0, 0, 1, 1, 1);

    // Load with start in ALARM: load wins, saturates, clears alarm
    start = 1'b1; do_load(2, 12, 7, 4); push_exp("load_sat", 29, 54, 0, 0, 0, 0);
    do_load(0, 0, 0, 0);   push_exp("load_zero", 0, 0, 0, 0, 0, 0);
    start = 1'b1; cyc();   push_exp("start_zero", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    do_load(0, 5, 3, 0);   push_exp("load_0530", 5, 30, 0, 0, 0, 0);
    start = 1'b1; cyc();
    tick(3);               push_exp("rst_pre", 5, 27, 1, 0, 0, 0);
    tick(1);
    #2 res = 1'b0;
    push_exp("rst_async", 0, 0, 0, 0, 0, 0);
    #4 res = 1'b1;
    start = 1'b1; cyc();   push_exp("rst_start", 0, 0, 0, 0, 0, 0);

    cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_mmss.md
# countdown_mmss

Minutes:seconds countdown timer; the down-counting counterpart to the clock's up-counting seconds/minutes chain. It sits beside the clock counters on the same 1 Hz enable tick. A BCD value is loaded, started, paused and resumed, and the block decrements once per tick with digit borrow. When the count reaches 00:00 it raises a done pulse and an alarm flag.

## Interface

**Parameters**
- `ALARM_TICKS`, default 10: number of `ena` ticks the alarm stays asserted before auto-clearing; 0 means hold until `ack` or `load`.

**Ports**
- `clk`  in  1  system clock.
- `res`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  one-`clk`-cycle tick at 1 Hz; all counting happens only on cycles with `ena`=1.
- `load`  in  1  load `set_*` digits into the count.
- `set_so`  in  4  seconds-ones load value.
- `set_st`  in  3  seconds-tens load value.
- `set_mo`  in  4  minutes-ones load value.
- `set_mt`  in  3  minutes-tens load value.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting.
- `ack`  in  1  clear alarm.
- `so`  out  4  seconds-ones, registered.
- `st`  out  3  seconds-tens, registered.
- `mo`  out  4  minutes-ones, registered.
- `mt`  out  3  minutes-tens, registered.
- `running`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on reaching 00:00.
- `alarm`  out  1  alarm indication.

## Operation

**Reset**
- `res`=0 forces state IDLE.
- All digits reset to 0.
- `running`, `done` and `alarm` reset to 0.
- The alarm tick counter resets to 0.

**State machine (IDLE, RUN, PAUSE, ALARM)**
- IDLE
  - `start` with count ≠ 00:00 → RUN.
  - `start` with count = 00:00 is ignored.
- RUN
  - `stop` → PAUSE.
  - On an `ena` tick the count decrements.
  - If the decrement yields 00:00 → ALARM, with `done`=1 for that cycle.
- PAUSE
  - `start` → RUN.
  - The count is frozen.
- ALARM
  - `ack` or `load` → IDLE.
  - With `ALARM_TICKS`>0, once `ALARM_TICKS` `ena` ticks have elapsed in ALARM → IDLE.

**Priority and acceptance rules**
- `stop` beats `start` when both are asserted in the same cycle.
- `load` is accepted in IDLE, PAUSE and ALARM; it is ignored in RUN.
- A load always leaves the block in IDLE, including from PAUSE.
- If `load` and `start` are asserted together in an accepting state, the load wins and state becomes IDLE; `start` is ignored that cycle.

**Load saturation**
- Ones digits greater than 9 load as 9.
- Tens digits greater than 5 load as 5.

**Decrement with borrow (per tick in RUN)**
- If `so`>0, `so`−1.
- Otherwise `so`=9, and:
  - if `st`>0, `st`−1;
  - otherwise `st`=5, and `mo`/`mt` borrow identically.
    - Minutes ones borrow from 0 to 9.
    - Minutes tens is never decremented below 0, because RUN exits at 00:00.

**Flags**
- In ALARM the count stays at 00:00.
- `done` is never asserted outside the RUN→ALARM transition.

## Timing

- All outputs are registered and update on the rising `clk` edge.
- `start`, `stop`, `ack` and `load` are level-sampled each `clk`. Asserting any of them for one cycle is sufficient.
- Start latency: `start` sampled at edge N puts `running`=1 after edge N. The first decrement happens on the first `ena` tick after edge N.
- Tick coincident with start: an `ena` tick in the same cycle as the accepting `start` does not decrement.
- Tick coincident with stop: an `ena` tick in the same cycle as `stop` in RUN does not decrement; stop takes effect first.
- The display digits reach 00:00 on the same edge that `done` rises. `done` falls at the next edge.
- `alarm` rises on the same edge as `done`.
- `ALARM_TICKS` counting starts with the first `ena` tick strictly after entry to ALARM.
- Asserting `res` mid-count clears everything immediately (asynchronous). The first state update after release occurs on the first `clk` edge following release.

## Configuration

- Macro: `COUNTDOWN_BLINK_EN`.
- Defined: while in ALARM, `alarm` toggles on every `ena` tick, starting high on entry (1 Hz blink for a buzzer or LED).
- Undefined: `alarm` is held steadily high for the whole ALARM state.
- In both cases `alarm`=0 outside ALARM, and the `ALARM_TICKS` behaviour is unchanged.

## Test plan

- Load 01:00, start, apply 60 ticks:
  - after tick 1 → 00:59;
  - after tick 60 → 00:00, `done` high for one cycle, `alarm`=1, `running`=0.
- Borrow chain: load 10:00, start, apply 1 tick → 09:59.
- Pause:
  - load 00:05, start, apply 2 ticks → 00:03;
  - assert `stop` together with a tick → stays 00:03;
  - apply 3 ticks → unchanged;
  - `start`, then 3 ticks → 00:00 with alarm.
- Rejected load and start:
  - `load` during RUN is ignored;
  - `start` with 00:00 loaded leaves `running`=0;
  - load value mo=12, st=7 → loads as mo=9, st=5.
- Alarm clearing:
  - with `ALARM_TICKS`=3, after reaching 00:00 `alarm` clears and state is IDLE after the 3rd tick;
  - with `ALARM_TICKS`=0, `alarm` holds through 20 ticks and clears one cycle after `ack`;
  - with `COUNTDOWN_BLINK_EN` defined, `alarm` toggles 1,0,1,… per tick.
- Reset mid-run: load 05:30, start, 4 ticks, pulse `res` low between edges → all outputs 0 immediately; `start` after release is ignored (count 00:00).
